// File: rtl/ads5296_pkg.sv
// Shared definitions for the ADS5296 frame-clock alignment slice: state
// encoding, the legal frame-clock nibbles and counter-width helpers.
package ads5296_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    localparam logic [3:0] FCLK_P0 = 4'b1111;
    localparam logic [3:0] FCLK_P1 = 4'b0001;
    localparam logic [3:0] FCLK_P2 = 4'b1100;
    localparam logic [3:0] FCLK_P3 = 4'b0111;
    localparam logic [3:0] FCLK_P4 = 4'b0000;

    localparam int LOST_W = 16;

    // Bits needed to hold the value max_val itself.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // True when cur is the legal successor of prev in the repeating frame pattern.
    function automatic logic fclk_pair_legal(input logic [3:0] prev, input logic [3:0] cur);
        return ((prev == FCLK_P0) && (cur == FCLK_P1)) ||
               ((prev == FCLK_P1) && (cur == FCLK_P2)) ||
               ((prev == FCLK_P2) && (cur == FCLK_P3)) ||
               ((prev == FCLK_P3) && (cur == FCLK_P4)) ||
               ((prev == FCLK_P4) && (cur == FCLK_P0));
    endfunction

endpackage

// File: rtl/ads5296_fclk_check.sv
// Two-stage history of the deserialized frame clock and a registered
// legal-transition flag; shared with the demux error counter.
module ads5296_fclk_check
    import ads5296_pkg::*;
(
    input  logic       lclk_d4,
    input  logic       rst_n,
    input  logic [3:0] fclk4b,
    output logic       good
);

    logic [3:0] fclk4b_r;
    logic [3:0] fclk4b_rr;

    always_ff @(posedge lclk_d4 or negedge rst_n) begin
        if (!rst_n) begin
            fclk4b_r  <= '0;
            fclk4b_rr <= '0;
            good      <= 1'b0;
        end else begin
            fclk4b_r  <= fclk4b;
            fclk4b_rr <= fclk4b_r;
            good      <= fclk_pair_legal(fclk4b_rr, fclk4b_r);
        end
    end

endmodule

// File: rtl/ads5296_fclk_align.sv
// Frame-clock bit-alignment controller: slips the SERDES until the frame
// pattern is legal, confirms lock, pulses sync and re-acquires on loss.
module ads5296_fclk_align
    import ads5296_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_CYCLES   = 64,
    parameter int MAX_SLIPS     = 8,
    parameter int UNLOCK_ERRS   = 4
) (
    input  logic              lclk_d4,
    input  logic              rst_n,
    input  logic [3:0]        fclk4b,
    input  logic              restart,
    output logic              bitslip,
    output logic              locked,
    output logic              sync_out,
    output logic              fail,
    output logic [3:0]        slip_cnt,
    output logic [LOST_W-1:0] lost_cnt
);

    localparam int WAIT_W = cnt_w(SETTLE_CYCLES);
    localparam int GOOD_W = cnt_w(LOCK_CYCLES);
    localparam int BAD_W  = cnt_w(UNLOCK_ERRS);

    localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_CYCLES - 1);
    localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_ERRS - 1);
    localparam logic [3:0]        SLIPS_MAX   = 4'(MAX_SLIPS);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic              good;

    ads5296_fclk_check u_check (
        .lclk_d4 (lclk_d4),
        .rst_n   (rst_n),
        .fclk4b  (fclk4b),
        .good    (good)
    );

    // A bad sample always beats the final good count, and restart beats everything.
    always_ff @(posedge lclk_d4 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            bitslip  <= 1'b0;
            locked   <= 1'b0;
            sync_out <= 1'b0;
            fail     <= 1'b0;
            slip_cnt <= '0;
            lost_cnt <= '0;
        end else begin
            bitslip  <= 1'b0;
            sync_out <= 1'b0;
            if (restart) begin
                state    <= ST_WAIT;
                wait_cnt <= '0;
                good_cnt <= '0;
                bad_cnt  <= '0;
                slip_cnt <= '0;
                locked   <= 1'b0;
                fail     <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (wait_cnt == SETTLE_LAST) begin
                            state    <= ST_CHECK;
                            good_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (!good) begin
                            if (slip_cnt < SLIPS_MAX) begin
                                state    <= ST_SLIP;
                                bitslip  <= 1'b1;
                                slip_cnt <= slip_cnt + 1'b1;
                            end else begin
                                state <= ST_FAIL;
                                fail  <= 1'b1;
                            end
                        end else if (good_cnt == LOCK_LAST) begin
                            state    <= ST_LOCKED;
                            locked   <= 1'b1;
                            sync_out <= 1'b1;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    ST_SLIP: begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                    ST_LOCKED: begin
                        if (good) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt == UNLOCK_LAST) begin
                            state    <= ST_WAIT;
                            wait_cnt <= '0;
                            bad_cnt  <= '0;
                            locked   <= 1'b0;
                            slip_cnt <= '0;
                            if (lost_cnt != '1) begin
                                lost_cnt <= lost_cnt + 1'b1;
                            end
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end
                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end
                    default: begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ads5296_fclk_align.sv
// Bench for ads5296_fclk_align: a serial frame-clock model with a 4-position
// bit-slipping deserializer drives the DUT; outcomes come from that model.
module tb_ads5296_fclk_align;

    localparam int SETTLE   = 16;
    localparam int LOCK     = 64;
    localparam int MAXS     = 8;
    localparam int UNLOCK   = 4;
    localparam int LOCK_LAT = SETTLE + LOCK;

    logic        lclk_d4 = 1'b0;
    logic        rst_n   = 1'b0;
    logic        restart = 1'b0;
    logic [3:0]  fclk4b  = 4'b0000;
    logic        bitslip;
    logic        locked;
    logic        sync_out;
    logic        fail;
    logic [3:0]  slip_cnt;
    logic [15:0] lost_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] frame_bits = 20'b1111_0001_1100_0111_0000;
    logic [3:0]  legal_seq [5] = '{4'b1111, 4'b0001, 4'b1100, 4'b0111, 4'b0000};

    int         cyc         = 0;
    int         word_idx    = 0;
    int         offset      = 0;
    int         bs_count    = 0;
    int         sync_count  = 0;
    int         sync_cyc    = -1;
    int         last_bs_cyc = -1;
    int         min_gap     = 1000;
    int         bad_run     = 0;
    int         max_bad_run = 0;
    int         exp_lost    = 0;
    bit         const_mode  = 1'b0;
    logic [3:0] prev_nib    = 4'b0000;
    logic [3:0] inj_q [$];

    ads5296_fclk_align #(
        .SETTLE_CYCLES (SETTLE),
        .LOCK_CYCLES   (LOCK),
        .MAX_SLIPS     (MAXS),
        .UNLOCK_ERRS   (UNLOCK)
    ) dut (
        .lclk_d4  (lclk_d4),
        .rst_n    (rst_n),
        .fclk4b   (fclk4b),
        .restart  (restart),
        .bitslip  (bitslip),
        .locked   (locked),
        .sync_out (sync_out),
        .fail     (fail),
        .slip_cnt (slip_cnt),
        .lost_cnt (lost_cnt)
    );

    always #5 lclk_d4 = ~lclk_d4;

    // Deserialized nibble for a word when the frame stream is offset by off bits.
    function automatic logic [3:0] nib(input int word, input int off);
        logic [3:0] v;
        int b;
        for (int i = 0; i < 4; i++) begin
            b        = (4 * word + off + i) % 20;
            v[3 - i] = frame_bits[19 - b];
        end
        return v;
    endfunction

    function automatic bit is_legal(input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < 5; i++) begin
            if (legal_seq[i] === a) return (legal_seq[(i + 1) % 5] === b);
        end
        return 1'b0;
    endfunction

    // SERDES model: reacts to bitslip, feeds the next nibble, tracks bad-pair runs.
    initial begin
        logic [3:0] cur;
        forever begin
            @(posedge lclk_d4);
            #1;
            if (!rst_n) cyc = 0;
            else        cyc++;
            if (bitslip === 1'b1) begin
                if (last_bs_cyc >= 0 && (cyc - last_bs_cyc) < min_gap) min_gap = cyc - last_bs_cyc;
                last_bs_cyc = cyc;
                bs_count++;
                offset = (offset + 1) % 4;
            end
            if (sync_out === 1'b1) begin
                sync_count++;
                sync_cyc = cyc;
            end
            if (inj_q.size() > 0) cur = inj_q.pop_front();
            else if (const_mode)  cur = 4'b0000;
            else                  cur = nib(word_idx, offset);
            word_idx = (word_idx + 1) % 5;
            if (is_legal(prev_nib, cur)) begin
                bad_run = 0;
            end else begin
                bad_run++;
                if (bad_run > max_bad_run) max_bad_run = bad_run;
            end
            prev_nib = cur;
            fclk4b   = cur;
        end
    end

    task automatic applyStimulus(input int off, input bit cmode);
        @(negedge lclk_d4);
        rst_n       = 1'b0;
        restart     = 1'b0;
        offset      = off;
        const_mode  = cmode;
        bs_count    = 0;
        sync_count  = 0;
        sync_cyc    = -1;
        last_bs_cyc = -1;
        min_gap     = 1000;
        exp_lost    = 0;
        repeat (3) @(negedge lclk_d4);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input int budget, input bit want_fail, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge lclk_d4);
            if (!want_fail && locked === 1'b1) begin ok = 1'b1; break; end
            if (want_fail && fail === 1'b1)    begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge lclk_d4);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bitslip !== 1'b0 || sync_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_pulses: got bitslip=%b sync_out=%b expected 0 0", bitslip, sync_out);
        end
        n_checks++;
        if (locked !== 1'b0 || fail !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got locked=%b fail=%b expected 0 0", locked, fail);
        end
        n_checks++;
        if (slip_cnt !== 4'd0 || lost_cnt !== 16'd0) begin
            n_fail++; $display("[TB] FAIL reset_counts: got slip=%0d lost=%0d expected 0 0", slip_cnt, lost_cnt);
        end
    endtask

    task automatic test_aligned();
        bit ok;
        applyStimulus(0, 1'b0);
        wait_state(300, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL aligned_lock: got timeout expected lock"); end
        n_checks++;
        if (sync_cyc < LOCK_LAT || sync_cyc > LOCK_LAT + 2) begin
            n_fail++; $display("[TB] FAIL aligned_sync_time: got %0d expected %0d..%0d", sync_cyc, LOCK_LAT, LOCK_LAT + 2);
        end
        repeat (20) @(negedge lclk_d4);
        n_checks++;
        if (sync_count != 1) begin n_fail++; $display("[TB] FAIL aligned_sync_count: got %0d expected 1", sync_count); end
        n_checks++;
        if (bs_count != 0 || int'(slip_cnt) != 0) begin
            n_fail++; $display("[TB] FAIL aligned_slips: got pulses=%0d slip_cnt=%0d expected 0 0", bs_count, slip_cnt);
        end
        n_checks++;
        if (locked !== 1'b1 || fail !== 1'b0) begin
            n_fail++; $display("[TB] FAIL aligned_flags: got locked=%b fail=%b expected 1 0", locked, fail);
        end
    endtask

    task automatic test_rotated(input int off);
        bit ok;
        int exp_slips;
        exp_slips = (4 - off) % 4;
        applyStimulus(off, 1'b0);
        wait_state(1500, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL rot%0d_lock: got timeout expected lock", off); end
        n_checks++;
        if (bs_count != exp_slips) begin n_fail++; $display("[TB] FAIL rot%0d_pulses: got %0d expected %0d", off, bs_count, exp_slips); end
        n_checks++;
        if (int'(slip_cnt) != exp_slips) begin n_fail++; $display("[TB] FAIL rot%0d_slip_cnt: got %0d expected %0d", off, slip_cnt, exp_slips); end
        n_checks++;
        if (min_gap < SETTLE + 1) begin n_fail++; $display("[TB] FAIL rot%0d_gap: got %0d expected >= %0d", off, min_gap, SETTLE + 1); end
        n_checks++;
        if (sync_count != 1) begin n_fail++; $display("[TB] FAIL rot%0d_sync_count: got %0d expected 1", off, sync_count); end
    endtask

    task automatic test_fail_restart();
        bit ok;
        applyStimulus(0, 1'b1);
        wait_state(2000, 1'b1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL fail_reach: got timeout expected fail"); end
        n_checks++;
        if (bs_count != MAXS || int'(slip_cnt) != MAXS) begin
            n_fail++; $display("[TB] FAIL fail_slips: got pulses=%0d slip_cnt=%0d expected %0d", bs_count, slip_cnt, MAXS);
        end
        const_mode = 1'b0;
        offset     = 0;
        repeat (30) @(negedge lclk_d4);
        n_checks++;
        if (fail !== 1'b1 || locked !== 1'b0 || bs_count != MAXS) begin
            n_fail++; $display("[TB] FAIL fail_hold: got fail=%b locked=%b pulses=%0d expected 1 0 %0d", fail, locked, bs_count, MAXS);
        end
        restart = 1'b1;
        @(negedge lclk_d4);
        restart = 1'b0;
        n_checks++;
        if (fail !== 1'b0 || int'(slip_cnt) != 0 || bitslip !== 1'b0) begin
            n_fail++; $display("[TB] FAIL fail_restart: got fail=%b slip_cnt=%0d bitslip=%b expected 0 0 0", fail, slip_cnt, bitslip);
        end
        bs_count   = 0;
        sync_count = 0;
        wait_state(300, 1'b0, ok);
        n_checks++;
        if (!ok || bs_count != 0 || sync_count != 1) begin
            n_fail++; $display("[TB] FAIL fail_relock: got ok=%0d pulses=%0d syncs=%0d expected 1 0 1", ok, bs_count, sync_count);
        end
    endtask

    task automatic test_glitch(input int len, input bit skip_ahead);
        bit ok;
        bit lose;
        logic [3:0] v;
        @(negedge lclk_d4);
        max_bad_run = 0;
        for (int i = 1; i <= len; i++) begin
            if (skip_ahead) begin
                v = nib(word_idx + i, offset);
            end else begin
                v = 4'($urandom_range(0, 15));
                while (v == 4'b1111 || v == 4'b0001 || v == 4'b1100 || v == 4'b0111 || v == 4'b0000)
                    v = 4'($urandom_range(0, 15));
            end
            inj_q.push_back(v);
        end
        repeat (len + 10) @(negedge lclk_d4);
        lose = (max_bad_run >= UNLOCK);
        if (lose) exp_lost++;
        n_checks++;
        if (locked !== logic'(!lose)) begin
            n_fail++; $display("[TB] FAIL glitch%0d_locked: got %b expected %b", len, locked, !lose);
        end
        n_checks++;
        if (int'(lost_cnt) != exp_lost) begin
            n_fail++; $display("[TB] FAIL glitch%0d_lost_cnt: got %0d expected %0d", len, lost_cnt, exp_lost);
        end
        if (lose) begin
            bs_count   = 0;
            sync_count = 0;
            wait_state(300, 1'b0, ok);
            n_checks++;
            if (!ok || bs_count != 0 || int'(slip_cnt) != 0 || sync_count != 1) begin
                n_fail++; $display("[TB] FAIL glitch%0d_relock: got ok=%0d pulses=%0d slip=%0d syncs=%0d expected 1 0 0 1",
                                   len, ok, bs_count, slip_cnt, sync_count);
            end
        end
    endtask

    task automatic test_restart_at_lock();
        bit ok;
        int guard;
        applyStimulus(0, 1'b0);
        guard = 0;
        while (cyc != LOCK_LAT - 1 && guard < 500) begin
            @(negedge lclk_d4);
            guard++;
        end
        restart = 1'b1;
        @(negedge lclk_d4);
        restart = 1'b0;
        repeat (3) @(negedge lclk_d4);
        n_checks++;
        if (sync_count != 0 || locked !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rsl_no_sync: got syncs=%0d locked=%b expected 0 0", sync_count, locked);
        end
        wait_state(300, 1'b0, ok);
        n_checks++;
        if (!ok || sync_cyc < 2 * LOCK_LAT || sync_cyc > 2 * LOCK_LAT + 2) begin
            n_fail++; $display("[TB] FAIL rsl_relock_time: got ok=%0d cycle=%0d expected %0d..%0d", ok, sync_cyc, 2 * LOCK_LAT, 2 * LOCK_LAT + 2);
        end
        repeat (20) @(negedge lclk_d4);
        n_checks++;
        if (sync_count != 1) begin n_fail++; $display("[TB] FAIL rsl_sync_count: got %0d expected 1", sync_count); end
    endtask

    task automatic test_reset_mid_slip();
        bit found;
        applyStimulus(2, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge lclk_d4);
            #2;
            if (bitslip === 1'b1) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found || int'(slip_cnt) != 1) begin
            n_fail++; $display("[TB] FAIL mid_slip_seen: got found=%0d slip_cnt=%0d expected 1 1", found, slip_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bitslip !== 1'b0 || sync_out !== 1'b0 || locked !== 1'b0 || fail !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_slip_flags: got bs=%b sync=%b locked=%b fail=%b expected 0 0 0 0",
                               bitslip, sync_out, locked, fail);
        end
        n_checks++;
        if (slip_cnt !== 4'd0 || lost_cnt !== 16'd0) begin
            n_fail++; $display("[TB] FAIL mid_slip_counts: got slip=%0d lost=%0d expected 0 0", slip_cnt, lost_cnt);
        end
        @(negedge lclk_d4);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_rotated(2);
        test_rotated($urandom_range(1, 3));
        test_fail_restart();
        test_glitch(3, 1'b1);
        test_glitch(6, 1'b0);
        test_restart_at_lock();
        test_reset_mid_slip();
        repeat (5) @(negedge lclk_d4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
